// File: rtl/op_fetch_pkg.sv
// Shared types and constants for the opcode fetch sequencer.
// OP_W is the opcode width; state_t is the sequencer FSM encoding.
package op_fetch_pkg;

  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] OP_RESET = 3'b000;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    ISSUE,
    WAIT_STEP,
    HALT
  } state_t;

endpackage

// File: rtl/op_prog_mem.sv
// Program memory: DEPTH x OP_W, one write port, one registered read port.
// Ports: clk, we/wa/wd write port, re/ra read port, rd registered data.
module op_prog_mem
  import op_fetch_pkg::*;
#(
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            we,
  input  logic [AW-1:0]   wa,
  input  logic [OP_W-1:0] wd,
  input  logic            re,
  input  logic [AW-1:0]   ra,
  output logic [OP_W-1:0] rd
);

  logic [OP_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we)
      mem[wa] <= wd;
    if (re)
      rd <= mem[ra];
  end

endmodule

// File: rtl/op_fetch.sv
// Opcode fetch sequencer feeding the opcode decoder over valid/ready.
// Ports: sys_clk, sys_rst_n (async low), wr_en/wr_addr/wr_data program
// write, end_addr, start, step_mode, step, opcode/op_valid/op_ready,
// pc, busy, done. Macro OP_FETCH_LOOP_EN: wrap at end_addr, never done.
module op_fetch
  import op_fetch_pkg::*;
#(
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic            sys_clk,
  input  logic            sys_rst_n,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic [OP_W-1:0] wr_data,
  input  logic [AW-1:0]   end_addr,
  input  logic            start,
  input  logic            step_mode,
  input  logic            step,
  output logic [OP_W-1:0] opcode,
  output logic            op_valid,
  input  logic            op_ready,
  output logic [AW-1:0]   pc,
  output logic            busy,
  output logic            done
);

  state_t          state;
  logic [AW-1:0]   end_q;
  logic [OP_W-1:0] rd_data;
  logic            idle_like;
  logic            mem_we;
  logic            mem_re;

  assign idle_like = (state == IDLE) || (state == HALT);
  assign mem_we    = wr_en && idle_like;
  assign mem_re    = (state == FETCH);

  // Read data is held between fetches, so gating by op_valid gives a
  // stable opcode during stalls and a defined value otherwise.
  assign opcode = op_valid ? rd_data : OP_RESET;

  op_prog_mem #(
    .DEPTH(DEPTH)
  ) u_mem (
    .clk(sys_clk),
    .we (mem_we),
    .wa (wr_addr),
    .wd (wr_data),
    .re (mem_re),
    .ra (pc),
    .rd (rd_data)
  );

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state    <= IDLE;
      pc       <= '0;
      end_q    <= '0;
      op_valid <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      unique case (state)
        IDLE, HALT: begin
          if (start) begin
            pc    <= '0;
            end_q <= end_addr;
            done  <= 1'b0;
            busy  <= 1'b1;
            state <= FETCH;
          end
        end
        FETCH: begin
          op_valid <= 1'b1;
          state    <= ISSUE;
        end
        ISSUE: begin
          if (op_ready) begin
            op_valid <= 1'b0;
            if (pc == end_q) begin
`ifdef OP_FETCH_LOOP_EN
              pc    <= '0;
              state <= step_mode ? WAIT_STEP : FETCH;
`else
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= HALT;
`endif
            end else begin
              pc    <= pc + AW'(1);
              state <= step_mode ? WAIT_STEP : FETCH;
            end
          end
        end
        WAIT_STEP: begin
          if (step)
            state <= FETCH;
        end
        default: begin
          op_valid <= 1'b0;
          busy     <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule
